// File: rtl/mux4_sel_arbiter_pkg.sv
// Shared constants and FSM encoding for the 4-source mux select arbiter.
package mux_arb_pkg;
  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/mux4_sel_arbiter_if.sv
// Request/select bundle between the sources and the arbiter driving the mux select.
interface mux4_sel_arbiter_if;
  logic [mux_arb_pkg::N_SRC-1:0] req;
  logic                          done;
  logic [mux_arb_pkg::SEL_W-1:0] sel;
  logic [mux_arb_pkg::N_SRC-1:0] gnt;
  logic                          busy;
  logic                          timeout;

  modport master (output req, done, input sel, gnt, busy, timeout);
  modport slave  (input req, done, output sel, gnt, busy, timeout);
endinterface

// File: rtl/mux4_sel_arbiter_rr_pick4.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] cand;

  always_comb begin
    any  = |req;
    idx  = ptr;
    cand = ptr;
    // Descending scan so the candidate closest to ptr wins.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end
endmodule

// File: rtl/mux4_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select; all outputs registered.
// Optional forced release after MAX_HOLD grant cycles: MUX4_SEL_ARB_TIMEOUT_EN.
module mux4_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int HW       = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux4_sel_arbiter_if.slave  bus
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || MAX_HOLD >= (1 << HW))
    $error("mux4_sel_arbiter: MAX_HOLD out of range for HW");

  state_t           state, state_nx;
  logic [SEL_W-1:0] ptr, ptr_nx, sel_q, sel_nx;
  logic [N_SRC-1:0] gnt_q, gnt_nx;
  logic             busy_q, busy_nx, to_q, to_nx;
  logic             any;
  logic [SEL_W-1:0] idx;
  logic             forced, rel;

  rr_pick4 u_pick (.req(bus.req), .ptr(ptr), .any(any), .idx(idx));

`ifdef MUX4_SEL_ARB_TIMEOUT_EN
  logic [HW-1:0] cnt;

  // Cleared while idle so every grant starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (state == ST_IDLE)  cnt <= '0;
    else if (!bus.done)         cnt <= cnt + 1'b1;
  end

  assign forced = (state == ST_GRANT) && !bus.done && (cnt == HW'(MAX_HOLD - 1));
`else
  assign forced = 1'b0;
`endif

  assign rel = (state == ST_GRANT) && (bus.done || forced);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (any) state_nx = ST_GRANT;
      ST_GRANT: if (rel) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; sel is retained across release.
  always_comb begin
    ptr_nx  = ptr;
    sel_nx  = sel_q;
    gnt_nx  = gnt_q;
    busy_nx = busy_q;
    to_nx   = 1'b0;
    if (state == ST_IDLE && any) begin
      sel_nx  = idx;
      gnt_nx  = N_SRC'(1) << idx;
      busy_nx = 1'b1;
    end else if (rel) begin
      gnt_nx  = '0;
      busy_nx = 1'b0;
      ptr_nx  = sel_q + 1'b1;
      to_nx   = forced;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      sel_q  <= '0;
      gnt_q  <= '0;
      busy_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      ptr    <= ptr_nx;
      sel_q  <= sel_nx;
      gnt_q  <= gnt_nx;
      busy_q <= busy_nx;
      to_q   <= to_nx;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Scoreboard bench: driver pushes model-predicted outputs, monitor compares each cycle.
module tb_mux4_sel_arbiter;
`ifdef MUX4_SEL_ARB_TIMEOUT_EN
  localparam int MH    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MH    = 15;
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux4_sel_arbiter_if bus ();
  mux4_sel_arbiter #(.MAX_HOLD(MH), .HW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_chk = 0, n_pass = 0;
  exp_t q[$];

  // Reference model: owner index (-1 = nobody), pointer, hold cycles, last select.
  int         owner = -1, mptr = 0, mhold = 0;
  logic [1:0] msel = 2'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req_v);
    n_chk++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
  endtask

  task automatic model_reset();
    owner = -1; mptr = 0; mhold = 0; msel = 2'd0;
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    exp_t e;
    logic to;
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
    to = 1'b0;
    if (owner < 0) begin
      if (r != 4'd0) begin
        for (int k = 0; k < 4; k++)
          if (owner < 0 && r[(mptr + k) % 4]) owner = (mptr + k) % 4;
        msel  = 2'(owner);
        mhold = 0;
      end
    end else if (d || (TO_EN && mhold == MH - 1)) begin
      to    = !d;
      mptr  = (owner + 1) % 4;
      owner = -1;
    end else begin
      mhold++;
    end
    e.sel     = msel;
    e.gnt     = (owner < 0) ? 4'd0 : 4'(1 << owner);
    e.busy    = (owner >= 0);
    e.timeout = to;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req  = 4'd0;
    bus.done = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_gnt", 8'(bus.gnt), 8'h0);
    chk("rst_sel", 8'(bus.sel), 8'h0);
    chk("rst_busy", 8'(bus.busy), 8'h0);
    chk("rst_timeout", 8'(bus.timeout), 8'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: outputs are flops, so sample shortly after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sel", 8'(bus.sel), 8'(e.sel));
        chk("gnt", 8'(bus.gnt), 8'(e.gnt));
        chk("busy", 8'(bus.busy), 8'(e.busy));
        chk("timeout", 8'(bus.timeout), 8'(e.timeout));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req  = 4'd0;
    bus.done = 1'b0;
    do_reset();

    // Mid-grant reset with gnt=0100, then first grant with all requesting.
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    do_reset();
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b0);

    // Single requester, held then released; sel stays put afterwards.
    do_reset();
    step(4'b0100, 1'b0);
    repeat (3) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    repeat (2) step(4'b0000, 1'b0);

    // Rotation with done on every grant cycle.
    do_reset();
    repeat (10) step(4'b1111, 1'b1);
    step(4'b0000, 1'b0);

    // Wrap and skip: ptr=3 -> source 1, then ptr=2 -> source 0.
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0011, 1'b0);
    step(4'b0000, 1'b1);

    // Freeze: requests change during grant, owner drops its request.
    step(4'b0010, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b0);

    // done while idle does nothing.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Hold limit: never done, then done exactly on the last allowed cycle.
    step(4'b0001, 1'b0);
    repeat (6) step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    repeat (3) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) do_reset();
      step(($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0));
    end
    step(4'b0000, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
